// File: rtl/l2_line_fill.sv
// -----------------------------------------------------------------------------
// l2_line_fill
//
// Line-fill engine for the L2 data array. It takes a miss from the L2 miss
// logic, reads one line from memory as WIDTH/BEAT beats, and assembles the
// beats into a line. It then writes the line into the array in a single cycle.
// After a demand fill it can also fill the next sequential line into the next
// set. A prefetch fill never starts another prefetch.
//
// Parameters
//   WIDTH        line width in bits; equals the data width of the array
//   BEAT         memory beat width in bits; WIDTH must be a multiple of BEAT
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   fill_req     demand fill request, held until fill_ack
//   fill_addr    line address; the offset bits are forced to zero
//   fill_index   target set
//   pf_enable    next-line fill enable, sampled in a demand COMMIT cycle
//   fill_ack     request accepted (combinational)
//   fill_done    one-cycle pulse in the COMMIT cycle of a demand fill
//   pf_done      one-cycle pulse in the COMMIT cycle of a prefetch fill
//   busy         engine not idle
//   mem_read     memory read request, held for the whole burst
//   mem_addr     line base address, stable for the whole burst
//   mem_resp     one pulse per valid beat
//   mem_rdata    beat data
//   array_write  array write enable, one cycle per fill
//   array_index  array write set
//   array_datain assembled line
// -----------------------------------------------------------------------------
module l2_line_fill #(
  parameter int WIDTH = 128,
  parameter int BEAT  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fill_req,
  input  logic [15:0]      fill_addr,
  input  logic [3:0]       fill_index,
  input  logic             pf_enable,
  output logic             fill_ack,
  output logic             fill_done,
  output logic             pf_done,
  output logic             busy,
  output logic             mem_read,
  output logic [15:0]      mem_addr,
  input  logic             mem_resp,
  input  logic [BEAT-1:0]  mem_rdata,
  output logic             array_write,
  output logic [3:0]       array_index,
  output logic [WIDTH-1:0] array_datain
);

  localparam int BEATS  = WIDTH / BEAT;
  localparam int CW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFFS   = $clog2(WIDTH / 8);
  localparam logic [15:0] STRIDE = 16'(WIDTH / 8);

  if ((WIDTH % BEAT) != 0) begin : g_bad_width
    $error("l2_line_fill: WIDTH must be an integer multiple of BEAT");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    beat_cnt_q;
  logic             is_pf_q;
  logic [15:0]      addr_q;
  logic [3:0]       set_q;
  logic [WIDTH-1:0] line_q;      // beats collected so far
  logic [WIDTH-1:0] line_merged; // line_q with the beat arriving this cycle
  logic [3:0]       out_index_q; // array outputs hold outside COMMIT
  logic [WIDTH-1:0] out_data_q;
  logic             last_beat;
  logic             pf_start;

  assign last_beat = (beat_cnt_q == CW'(BEATS - 1));
  assign pf_start  = !is_pf_q && pf_enable;

  // NOTE: every signal assigned in an always_comb gets a default first.
  // Without the default, a branch that does not assign the signal infers a latch.
  always_comb begin
    line_merged = line_q;
    line_merged[BEAT*int'(beat_cnt_q) +: BEAT] = mem_rdata;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fill_req) state_d = FETCH;
      FETCH:   if (mem_resp && last_beat) state_d = COMMIT;
      COMMIT:  state_d = pf_start ? FETCH : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // fill_ack is gated by rst_n so that it stays low while reset is held,
  // even though the state already reads IDLE during reset.
  assign fill_ack     = rst_n && fill_req && (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign mem_read     = (state_q == FETCH);
  assign mem_addr     = addr_q;
  assign array_write  = (state_q == COMMIT);
  assign fill_done    = (state_q == COMMIT) && !is_pf_q;
  assign pf_done      = (state_q == COMMIT) && is_pf_q;
  assign array_index  = out_index_q;
  assign array_datain = out_data_q;

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples its pre-edge value, so the simulator's evaluation order cannot
  // change the result.
  // NOTE: the line and output registers are reset together with the control
  // state. This drives every output to zero during reset and discards a
  // partial line when reset arrives mid-burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      is_pf_q     <= 1'b0;
      addr_q      <= '0;
      set_q       <= '0;
      line_q      <= '0;
      out_index_q <= '0;
      out_data_q  <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (fill_req) begin
            addr_q     <= {fill_addr[15:OFFS], {OFFS{1'b0}}};
            set_q      <= fill_index;
            is_pf_q    <= 1'b0;
            beat_cnt_q <= '0;
          end
        end
        FETCH: begin
          if (mem_resp) begin
            line_q     <= line_merged;
            beat_cnt_q <= beat_cnt_q + CW'(1);
            if (last_beat) begin
              out_data_q  <= line_merged;
              out_index_q <= set_q;
            end
          end
        end
        COMMIT: begin
          // Next-line prefetch. Both the address and the set wrap naturally.
          if (pf_start) begin
            addr_q     <= addr_q + STRIDE;
            set_q      <= set_q + 4'd1;
            is_pf_q    <= 1'b1;
            beat_cnt_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_line_fill.sv
// -----------------------------------------------------------------------------
// tb_l2_line_fill
//
// Directed testbench for l2_line_fill. Each scenario task drives its own
// stimulus and compares the DUT outputs against hand-computed values. A small
// monitor counts array writes and done pulses at every falling edge.
// -----------------------------------------------------------------------------
module tb_l2_line_fill;

  logic         clk;
  logic         rst_n;
  logic         fill_req;
  logic [15:0]  fill_addr;
  logic [3:0]   fill_index;
  logic         pf_enable;
  logic         fill_ack;
  logic         fill_done;
  logic         pf_done;
  logic         busy;
  logic         mem_read;
  logic [15:0]  mem_addr;
  logic         mem_resp;
  logic [31:0]  mem_rdata;
  logic         array_write;
  logic [3:0]   array_index;
  logic [127:0] array_datain;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int fd_cnt   = 0;
  int pd_cnt   = 0;
  bit stab_err;
  bit ack_seen;

  l2_line_fill #(.WIDTH(128), .BEAT(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fill_req     (fill_req),
    .fill_addr    (fill_addr),
    .fill_index   (fill_index),
    .pf_enable    (pf_enable),
    .fill_ack     (fill_ack),
    .fill_done    (fill_done),
    .pf_done      (pf_done),
    .busy         (busy),
    .mem_read     (mem_read),
    .mem_addr     (mem_addr),
    .mem_resp     (mem_resp),
    .mem_rdata    (mem_rdata),
    .array_write  (array_write),
    .array_index  (array_index),
    .array_datain (array_datain)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (array_write === 1'b1) wr_cnt++;
    if (fill_done === 1'b1)   fd_cnt++;
    if (pf_done === 1'b1)     pd_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise a request and wait, with a bound, for fill_ack. Returns in the first
  // FETCH cycle, one time unit after the accepting edge.
  task automatic start_req(input logic [15:0] addr, input logic [3:0] idx,
                           output bit ok, output int waited);
    fill_req   = 1'b1;
    fill_addr  = addr;
    fill_index = idx;
    ok         = 1'b0;
    waited     = 0;
    while (!ok && waited < 50) begin
      @(negedge clk);
      if (fill_ack === 1'b1) ok = 1'b1;
      else begin
        waited++;
        tick();
      end
    end
    tick();
    fill_req = 1'b0;
  endtask

  // Drive n beats of a line with gap idle cycles between beats. Flags any
  // cycle where mem_read/mem_addr are not as expected, or fill_ack is high.
  task automatic feed(input logic [127:0] line, input int n, input int gap,
                      input logic [15:0] exp_addr);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          if (mem_read !== 1'b1 || mem_addr !== exp_addr) stab_err = 1'b1;
          if (fill_ack === 1'b1) ack_seen = 1'b1;
          tick();
        end
      end
      mem_resp  = 1'b1;
      mem_rdata = line[i*32 +: 32];
      @(negedge clk);
      if (mem_read !== 1'b1 || mem_addr !== exp_addr) stab_err = 1'b1;
      if (fill_ack === 1'b1) ack_seen = 1'b1;
      tick();
      mem_resp = 1'b0;
    end
  endtask

  task automatic test_reset();
    fill_req = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (fill_ack !== 1'b0) begin n_fail++; $display("FAIL reset_fill_ack: got %b expected 0", fill_ack); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (mem_read !== 1'b0 || mem_addr !== 16'h0) begin n_fail++; $display("FAIL reset_mem: got read=%b addr=%h expected 0/0000", mem_read, mem_addr); end
    n_checks++; if (array_write !== 1'b0 || array_index !== 4'h0 || array_datain !== 128'h0) begin n_fail++; $display("FAIL reset_array: got wr=%b idx=%h data=%h expected zeros", array_write, array_index, array_datain); end
    n_checks++; if (fill_done !== 1'b0 || pf_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b/%b expected 0/0", fill_done, pf_done); end
    fill_req = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
    tick();
  endtask

  task automatic test_demand();
    logic [127:0] l = 128'h44444444_33333333_22222222_11111111;
    bit ok; int w;
    pf_enable = 1'b0; wr_cnt = 0; fd_cnt = 0; pd_cnt = 0; stab_err = 1'b0;
    start_req(16'h1234, 4'd3, ok, w);
    n_checks++; if (!ok || w != 0) begin n_fail++; $display("FAIL demand_ack: got ok=%0d wait=%0d expected 1/0", ok, w); end
    feed(l, 4, 0, 16'h1230);
    n_checks++; if (stab_err) begin n_fail++; $display("FAIL demand_mem_addr: got unstable read/addr expected read=1 addr=1230"); end
    @(negedge clk);
    n_checks++; if (array_write !== 1'b1 || mem_read !== 1'b0) begin n_fail++; $display("FAIL demand_commit: got wr=%b read=%b expected 1/0", array_write, mem_read); end
    n_checks++; if (array_index !== 4'd3) begin n_fail++; $display("FAIL demand_index: got %h expected 3", array_index); end
    n_checks++; if (array_datain !== l) begin n_fail++; $display("FAIL demand_data: got %h expected %h", array_datain, l); end
    n_checks++; if (fill_done !== 1'b1 || pf_done !== 1'b0) begin n_fail++; $display("FAIL demand_done: got %b/%b expected 1/0", fill_done, pf_done); end
    tick();
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || array_write !== 1'b0) begin n_fail++; $display("FAIL demand_idle: got busy=%b wr=%b expected 0/0", busy, array_write); end
    n_checks++; if (array_datain !== l || array_index !== 4'd3) begin n_fail++; $display("FAIL demand_hold: got idx=%h data=%h expected 3/%h", array_index, array_datain, l); end
    tick();
    n_checks++; if (wr_cnt != 1 || fd_cnt != 1 || pd_cnt != 0) begin n_fail++; $display("FAIL demand_counts: got wr=%0d fd=%0d pd=%0d expected 1/1/0", wr_cnt, fd_cnt, pd_cnt); end
  endtask

  task automatic test_stalled();
    logic [127:0] l = 128'h44444444_33333333_22222222_11111111;
    bit ok; int w;
    pf_enable = 1'b0; wr_cnt = 0; fd_cnt = 0; stab_err = 1'b0;
    start_req(16'h1234, 4'd3, ok, w);
    feed(l, 4, 3, 16'h1230);
    n_checks++; if (stab_err || wr_cnt != 0) begin n_fail++; $display("FAIL stall_stable: got err=%0d writes=%0d expected 0/0", stab_err, wr_cnt); end
    @(negedge clk);
    n_checks++; if (array_write !== 1'b1 || array_datain !== l) begin n_fail++; $display("FAIL stall_data: got wr=%b data=%h expected 1/%h", array_write, array_datain, l); end
    tick();
    tick();
    n_checks++; if (wr_cnt != 1 || fd_cnt != 1) begin n_fail++; $display("FAIL stall_counts: got wr=%0d fd=%0d expected 1/1", wr_cnt, fd_cnt); end
  endtask

  task automatic test_prefetch_wrap();
    logic [127:0] la = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    logic [127:0] lb = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
    bit ok; int w;
    pf_enable = 1'b1; wr_cnt = 0; fd_cnt = 0; pd_cnt = 0; stab_err = 1'b0;
    start_req(16'hFFF0, 4'd15, ok, w);
    feed(la, 4, 0, 16'hFFF0);
    @(negedge clk);
    n_checks++; if (array_index !== 4'd15 || array_datain !== la || fill_done !== 1'b1 || pf_done !== 1'b0) begin n_fail++; $display("FAIL pf_demand_commit: got idx=%h fd=%b pd=%b data=%h expected f/1/0/%h", array_index, fill_done, pf_done, array_datain, la); end
    tick();
    feed(lb, 4, 0, 16'h0000);
    n_checks++; if (stab_err) begin n_fail++; $display("FAIL pf_wrap_addr: got unstable or wrong addr expected FFF0 then 0000"); end
    @(negedge clk);
    n_checks++; if (array_write !== 1'b1 || array_index !== 4'd0 || array_datain !== lb) begin n_fail++; $display("FAIL pf_commit: got wr=%b idx=%h data=%h expected 1/0/%h", array_write, array_index, array_datain, lb); end
    n_checks++; if (pf_done !== 1'b1 || fill_done !== 1'b0) begin n_fail++; $display("FAIL pf_done: got pd=%b fd=%b expected 1/0", pf_done, fill_done); end
    tick();
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pf_no_chain: got busy=%b expected 0", busy); end
    tick();
    n_checks++; if (wr_cnt != 2 || fd_cnt != 1 || pd_cnt != 1) begin n_fail++; $display("FAIL pf_counts: got wr=%0d fd=%0d pd=%0d expected 2/1/1", wr_cnt, fd_cnt, pd_cnt); end
    pf_enable = 1'b0;
  endtask

  task automatic test_req_during_pf();
    logic [127:0] lc = 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0;
    logic [127:0] ld = 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0;
    logic [127:0] le = 128'hE3E3E3E3_E2E2E2E2_E1E1E1E1_E0E0E0E0;
    bit ok; int w;
    pf_enable = 1'b1; fd_cnt = 0; pd_cnt = 0; stab_err = 1'b0; ack_seen = 1'b0;
    start_req(16'h4000, 4'd7, ok, w);
    feed(lc, 4, 0, 16'h4000);
    tick();
    fill_req = 1'b1; fill_addr = 16'h2000; fill_index = 4'd5; pf_enable = 1'b0;
    feed(ld, 4, 0, 16'h4010);
    @(negedge clk);
    n_checks++; if (pf_done !== 1'b1 || array_index !== 4'd8 || array_datain !== ld) begin n_fail++; $display("FAIL rdp_pf_commit: got pd=%b idx=%h data=%h expected 1/8/%h", pf_done, array_index, array_datain, ld); end
    if (fill_ack === 1'b1) ack_seen = 1'b1;
    n_checks++; if (ack_seen || stab_err) begin n_fail++; $display("FAIL rdp_no_ack: got ack_seen=%0d err=%0d expected 0/0", ack_seen, stab_err); end
    tick();
    start_req(16'h2000, 4'd5, ok, w);
    n_checks++; if (!ok || w != 0) begin n_fail++; $display("FAIL rdp_ack_first_idle: got ok=%0d wait=%0d expected 1/0", ok, w); end
    feed(le, 4, 0, 16'h2000);
    @(negedge clk);
    n_checks++; if (fill_done !== 1'b1 || array_index !== 4'd5 || array_datain !== le) begin n_fail++; $display("FAIL rdp_demand_commit: got fd=%b idx=%h data=%h expected 1/5/%h", fill_done, array_index, array_datain, le); end
    tick();
    tick();
    n_checks++; if (fd_cnt != 2 || pd_cnt != 1) begin n_fail++; $display("FAIL rdp_counts: got fd=%0d pd=%0d expected 2/1", fd_cnt, pd_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] lx = 128'h99999999_88888888_77777777_66666666;
    logic [127:0] lf = 128'hF3F3F3F3_F2F2F2F2_F1F1F1F1_F0F0F0F0;
    bit ok; int w;
    pf_enable = 1'b0; wr_cnt = 0;
    start_req(16'h3000, 4'd9, ok, w);
    feed(lx, 2, 0, 16'h3000);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (mem_read !== 1'b0 || busy !== 1'b0 || mem_addr !== 16'h0) begin n_fail++; $display("FAIL rmid_mem: got read=%b busy=%b addr=%h expected 0/0/0000", mem_read, busy, mem_addr); end
    n_checks++; if (array_write !== 1'b0 || array_index !== 4'h0 || array_datain !== 128'h0) begin n_fail++; $display("FAIL rmid_array: got wr=%b idx=%h data=%h expected zeros", array_write, array_index, array_datain); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++; if (wr_cnt != 0) begin n_fail++; $display("FAIL rmid_no_write: got %0d expected 0", wr_cnt); end
    start_req(16'h5557, 4'd2, ok, w);
    feed(lf, 4, 0, 16'h5550);
    @(negedge clk);
    n_checks++; if (array_write !== 1'b1 || array_index !== 4'd2 || array_datain !== lf) begin n_fail++; $display("FAIL rmid_refill: got wr=%b idx=%h data=%h expected 1/2/%h", array_write, array_index, array_datain, lf); end
    tick();
    tick();
  endtask

  task automatic test_spurious();
    logic [127:0] lg = 128'h0D0C0B0A_09080706_05040302_01000F0E;
    bit ok; int w;
    bit bad = 1'b0;
    wr_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      mem_resp  = 1'b1;
      mem_rdata = 32'hDEADBEEF;
      @(negedge clk);
      if (busy !== 1'b0 || mem_read !== 1'b0 || array_write !== 1'b0) bad = 1'b1;
      tick();
    end
    mem_resp = 1'b0;
    tick();
    n_checks++; if (bad || wr_cnt != 0) begin n_fail++; $display("FAIL spur_idle: got bad=%0d writes=%0d expected 0/0", bad, wr_cnt); end
    start_req(16'h6660, 4'd4, ok, w);
    feed(lg, 4, 0, 16'h6660);
    @(negedge clk);
    n_checks++; if (array_datain !== lg || array_index !== 4'd4) begin n_fail++; $display("FAIL spur_beat0: got idx=%h data=%h expected 4/%h", array_index, array_datain, lg); end
    tick();
    tick();
  endtask

  initial begin
    rst_n      = 1'b0;
    fill_req   = 1'b0;
    fill_addr  = 16'h0;
    fill_index = 4'h0;
    pf_enable  = 1'b0;
    mem_resp   = 1'b0;
    mem_rdata  = 32'h0;
    test_reset();
    test_demand();
    test_stalled();
    test_prefetch_wrap();
    test_req_during_pf();
    test_reset_mid();
    test_spurious();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
